fp_preadder_pipe: RTL

//   Pipelined, parametrised IEEE-754 add/sub pre-adder. Unpacks two operands, applies add/sub op,

---
 rtl/fp_preadder_pipe.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/fp_preadder_pipe.sv
// Two-stage IEEE-754 add/sub pre-adder: unpack/classify/order, then align with GRS and special-case mux.
// Define FP_PREADDER_FTZ_EN to flush denormal inputs to signed zero.
module fp_preadder_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W  = 1 + EXP_W + MAN_W,
  localparam int MW = MAN_W + 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign_great,
  output logic             sign_small,
  output logic [EXP_W-1:0] exp,
  output logic [MW-1:0]    man_great,
  output logic [MW-1:0]    man_small,
  output logic [W-1:0]     special_result,
  output logic             special_case,
  output logic [1:0]       loss
);

`ifdef FP_PREADDER_FTZ_EN
  localparam bit FTZ = 1'b1;
`else
  localparam bit FTZ = 1'b0;
`endif

  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  function automatic logic is_zero(input logic [W-1:0] x);
    return (x[W-2:MAN_W] == '0) && ((x[MAN_W-1:0] == '0) || FTZ);
  endfunction

  function automatic logic is_inf(input logic [W-1:0] x);
    return (&x[W-2:MAN_W]) && (x[MAN_W-1:0] == '0);
  endfunction

  function automatic logic is_nan(input logic [W-1:0] x);
    return (&x[W-2:MAN_W]) && (x[MAN_W-1:0] != '0);
  endfunction

  // {effective exponent, hidden bit, fraction}; also the magnitude ordering key
  function automatic logic [EXP_W+MAN_W:0] unpack(input logic [W-1:0] x);
    if (x[W-2:MAN_W] != '0) return {x[W-2:MAN_W], 1'b1, x[MAN_W-1:0]};
    if (is_zero(x))         return '0;
    return {EXP_W'(1), 1'b0, x[MAN_W-1:0]};
  endfunction

  // Returns {loss[1:0], aligned mantissa}; bits reaching position 0 or below fold into sticky
  function automatic logic [MW+1:0] align_small(input logic [MAN_W:0] sig,
                                                input logic [EXP_W-1:0] d);
    logic [MW-1:0] ext;
    logic [MW-1:0] shifted;
    logic [MW-1:0] mask;
    logic          sticky;
    ext = {1'b0, sig, 3'b000};
    if (int'(d) > MAN_W + 3) begin
      sticky = |sig;
      return {1'b1, sticky, {(MW-1){1'b0}}, sticky};
    end
    shifted = ext >> d;
    mask    = ~({MW{1'b1}} << (int'(d) + 1));
    sticky  = |(ext & mask);
    return {1'b0, sticky, shifted[MW-1:1], sticky};
  endfunction

  logic                 vld_p1;
  logic                 sign_g_p1, sign_s_p1;
  logic [EXP_W-1:0]     exp_g_p1, exp_s_p1;
  logic [MAN_W:0]       sig_g_p1, sig_s_p1;
  logic                 spec_p1;
  logic [W-1:0]         spec_res_p1;

  logic                 s2_adv;
  logic                 sa, sb, a_great, spec_n;
  logic [EXP_W+MAN_W:0] ua, ub;
  logic [W-1:0]         a_eff, b_eff, spec_res_n;
  logic [EXP_W-1:0]     shift_p1;
  logic [MW+1:0]        aligned_p1;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !rst && (!vld_p1 || s2_adv);

  // Stage 0 -> 1: unpack, classify, order by magnitude
  always_comb begin
    sa         = in_a[W-1];
    sb         = in_b[W-1] ^ in_op;
    a_eff      = {sa, in_a[W-2:0]};
    b_eff      = {sb, in_b[W-2:0]};
    ua         = unpack(in_a);
    ub         = unpack(in_b);
    a_great    = ua >= ub;
    spec_n     = 1'b1;
    spec_res_n = '0;
    if (is_nan(in_a) || is_nan(in_b))                spec_res_n = QNAN;
    else if (is_inf(in_a) && is_inf(in_b) && sa != sb) spec_res_n = QNAN;
    else if (is_inf(in_a))                           spec_res_n = a_eff;
    else if (is_inf(in_b))                           spec_res_n = b_eff;
    else if (is_zero(in_a) && is_zero(in_b))         spec_res_n = {sa & sb, {(W-1){1'b0}}};
    else if (is_zero(in_a))                          spec_res_n = b_eff;
    else if (is_zero(in_b))                          spec_res_n = a_eff;
    else                                             spec_n     = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)           vld_p1 <= 1'b0;
    else if (in_ready) vld_p1 <= in_valid;
    if (in_valid && in_ready) begin
      sign_g_p1              <= a_great ? sa : sb;
      sign_s_p1              <= a_great ? sb : sa;
      {exp_g_p1, sig_g_p1}   <= a_great ? ua : ub;
      {exp_s_p1, sig_s_p1}   <= a_great ? ub : ua;
      spec_p1                <= spec_n;
      spec_res_p1            <= spec_res_n;
    end
  end

  // Stage 1 -> 2: align smaller mantissa, mux special results
  assign shift_p1   = exp_g_p1 - exp_s_p1;
  assign aligned_p1 = align_small(sig_s_p1, shift_p1);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      sign_great     <= 1'b0;
      sign_small     <= 1'b0;
      exp            <= '0;
      man_great      <= '0;
      man_small      <= '0;
      special_result <= '0;
      special_case   <= 1'b0;
      loss           <= '0;
    end else if (s2_adv) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        special_case   <= spec_p1;
        special_result <= spec_p1 ? spec_res_p1 : '0;
        sign_great     <= !spec_p1 && sign_g_p1;
        sign_small     <= !spec_p1 && sign_s_p1;
        exp            <= spec_p1 ? '0 : exp_g_p1;
        man_great      <= spec_p1 ? '0 : {1'b0, sig_g_p1, 3'b000};
        man_small      <= spec_p1 ? '0 : aligned_p1[MW-1:0];
        loss           <= spec_p1 ? '0 : aligned_p1[MW+1:MW];
      end
    end
  end

endmodule
